alu_op_issue: RTL and testbench
===============================

Name: alu_op_issue

Overview:
- Issue stage directly upstream of the 4-to-16 opcode decoder in the 8-bit ALU datapath.
- Buffers incoming ALU instructions (4-bit opcode plus two 8-bit operands) in a small FIFO and presents one instruction at a time as registered, stable OP_CODE/OP_A/OP_B. OP_CODE feeds the decoder's 4-bit input.
- Holds each instruction until the ALU returns a result, then forwards that result downstream with valid/ready backpressure.
- Flags a timeout if the ALU never responds.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of 2, minimum 2).
- TIMEOUT, 16, maximum cycles in BUSY before the error is flagged (1..255).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  instruction offered.
- IN_READY  out  1  FIFO not full; an instruction is accepted when IN_VALID && IN_READY.
- IN_OPCODE  in  4  ALU opcode.
- IN_A  in  8  operand A.
- IN_B  in  8  operand B.
- OP_VALID  out  1  instruction currently presented to the decoder/ALU.
- OP_CODE  out  4  registered opcode, driven to the decoder input.
- OP_A  out  8  registered operand A.
- OP_B  out  8  registered operand B.
- RES_VALID  in  1  ALU result strobe (one cycle).
- RES_DATA  in  8  ALU result.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  downstream accepts the result.
- OUT_DATA  out  8  registered result.
- TIMEOUT_ERR  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FIFO emptied; FSM goes to IDLE.
  - All outputs 0, except IN_READY = 1 once RST_N is high.
  - Reset mid-operation discards the in-flight instruction and any buffered result. No partial output appears.
- FIFO:
  - Write on IN_VALID && IN_READY; read on the pop from IDLE.
  - Pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full = MSBs differ and low bits equal; empty = pointers equal.
  - IN_READY = !full, combinational from the registered pointers.
  - Simultaneous push and pop when full: the push is refused (IN_READY is already low); the pop proceeds.
  - Simultaneous push and pop when empty: the pop is not taken that cycle. There is no bypass; minimum latency from IN accept to OP_VALID is 2 cycles.
- FSM states IDLE, BUSY, HOLD:
  - IDLE, FIFO not empty: pop the head; load OP_CODE/OP_A/OP_B; OP_VALID goes to 1 next cycle; go to BUSY; clear the cycle counter.
  - IDLE, FIFO empty: OP_VALID = 0; OP_CODE/OP_A/OP_B keep their last values so the decoder input does not toggle.
  - BUSY: OP_* held stable. Counter increments each cycle.
    - On RES_VALID: register RES_DATA into OUT_DATA; OUT_VALID = 1; OP_VALID = 0; go to HOLD.
    - If the counter reaches TIMEOUT with no RES_VALID: set TIMEOUT_ERR; OP_VALID = 0; OUT_DATA = 8'hFF; OUT_VALID = 1; go to HOLD.
    - RES_VALID in the same cycle the counter reaches TIMEOUT: the result wins and no error is flagged.
  - HOLD: OUT_VALID and OUT_DATA held until OUT_READY.
    - On OUT_VALID && OUT_READY: OUT_VALID = 0 next cycle; return to IDLE.
    - No pop occurs in the same cycle as the OUT handshake, so the earliest next OP_VALID is 2 cycles after it.
  - RES_VALID outside BUSY is ignored.
- Widths: counter is 8 bits; no arithmetic on the data path; opcodes pass through unmodified, all 16 values legal.

Decomposition:
- Shared package alu_pkg:
  - opcode width (4), data width (8);
  - FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2);
  - TIMEOUT_DATA constant 8'hFF.
- One sub-module, alu_instr_fifo: parameterised DEPTH, 20-bit entry {opcode, A, B}, push/pop/full/empty.
- The FSM and output registers live in alu_op_issue.

Test Plan:
- Reset, then push opcode 4'h3, A = 8'h12, B = 8'h34.
  - Expected: 2 cycles later OP_VALID = 1 with OP_CODE = 3, OP_A = 12, OP_B = 34.
  - Then RES_VALID with RES_DATA = 8'h46 gives OUT_VALID = 1, OUT_DATA = 46 on the next cycle.
- Push 5 instructions back-to-back with OUT_READY held low.
  - Expected: IN_READY drops after the FIFO holds 4 entries and one is in flight.
  - Releasing OUT_READY drains the results in order, with opcodes 0..4 seen on OP_CODE.
- Issue opcode 4'hF and never assert RES_VALID.
  - Expected: after 16 BUSY cycles, TIMEOUT_ERR = 1, OUT_DATA = FF, OUT_VALID = 1.
  - The next instruction still issues normally and TIMEOUT_ERR stays 1.
- Assert RES_VALID in exactly the cycle the counter hits 16.
  - Expected: OUT_DATA = RES_DATA, TIMEOUT_ERR stays 0.
- Pulse RST_N low mid-BUSY with 3 entries queued.
  - Expected: immediately OP_VALID = 0, OUT_VALID = 0, FIFO empty, IN_READY = 1 after release; no stale result is ever output.
- Pulse RES_VALID while in IDLE and HOLD.
  - Expected: no change to OUT_DATA or state.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: field widths, FSM encoding,
// the instruction layout stored in the FIFO, and the result reported on timeout.
package alu_pkg;

  localparam int OPCODE_W = 4;
  localparam int DATA_W   = 8;
  localparam int ENTRY_W  = OPCODE_W + 2 * DATA_W;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } instr_t;

endpackage

// File: rtl/alu_instr_fifo.sv
// Instruction FIFO: DEPTH entries of {opcode, A, B}, extra-MSB pointers for full/empty,
// show-ahead read port (dout is the current head).
module alu_instr_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: queues instructions, presents one at a time on registered OP_* outputs,
// waits for the ALU result (or times out) and holds it for the downstream handshake.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic                op_valid,
  output logic [OPCODE_W-1:0] op_code,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  input  logic                res_valid,
  input  logic [DATA_W-1:0]   res_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                timeout_err
);

  // Last BUSY cycle before timeout: the counter reads TIMEOUT-1 during the TIMEOUT-th cycle.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT - 1);

  state_t             state;
  state_t             state_next;
  logic [7:0]         cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_dout;
  instr_t             head;
  logic               res_take;
  logic               timeout_hit;
  logic               out_done;

  alu_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   ({in_opcode, in_a, in_b}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head     = fifo_dout;
  assign in_ready = !fifo_full && rst_n;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    fifo_pop    = 1'b0;
    res_take    = 1'b0;
    timeout_hit = 1'b0;
    out_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (res_valid) begin
          res_take   = 1'b1;
          state_next = ST_HOLD;
        end else if (cnt == TIMEOUT_CNT) begin
          timeout_hit = 1'b1;
          state_next  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_done   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_valid    <= 1'b0;
      op_code     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      if (fifo_pop) begin
        op_valid <= 1'b1;
        op_code  <= head.opcode;
        op_a     <= head.a;
        op_b     <= head.b;
        cnt      <= '0;
      end else if (state == ST_BUSY) begin
        cnt <= cnt + 8'd1;
      end
      if (res_take || timeout_hit) begin
        op_valid  <= 1'b0;
        out_valid <= 1'b1;
        out_data  <= res_take ? res_data : TIMEOUT_DATA;
      end
      if (timeout_hit) timeout_err <= 1'b1;
      if (out_done)    out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: scoreboard queues of expected issued instructions and
// expected results, compared with immediate assertions when the DUT presents them.
module tb_alu_op_issue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_opcode = '0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       op_valid;
  logic [3:0] op_code;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;

  instr_t     exp_op_q[$];
  logic [7:0] exp_res_q[$];

  always #5 clk = ~clk;

  alu_op_issue #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_a        (in_a),
    .in_b        (in_b),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    instr_t e;
    check("push_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    e.opcode  = op;
    e.a       = a;
    e.b       = b;
    exp_op_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_issue(input string tag);
    instr_t e;
    for (int i = 0; i < 20 && !op_valid; i++) tick();
    check({tag, "_seen"}, op_valid, 1);
    e = (exp_op_q.size() != 0) ? exp_op_q.pop_front() : '0;
    check({tag, "_code"}, op_code, e.opcode);
    check({tag, "_a"}, op_a, e.a);
    check({tag, "_b"}, op_b, e.b);
  endtask

  task automatic respond(input logic [7:0] data);
    res_valid = 1'b1;
    res_data  = data;
    exp_res_q.push_back(data);
    tick();
    res_valid = 1'b0;
    check("resp_out_valid", out_valid, 1);
    check("resp_out_data", out_data, data);
    check("resp_op_valid", op_valid, 0);
  endtask

  task automatic take_result(input string tag);
    logic [7:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check({tag, "_valid"}, out_valid, 1);
    e = (exp_res_q.size() != 0) ? exp_res_q.pop_front() : 8'h00;
    check({tag, "_data"}, out_data, e);
    tick();
    out_ready = 1'b0;
    check({tag, "_released"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: everything low, including in_ready while reset is held.
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_code", op_code, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_timeout", timeout_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Single instruction: two-cycle issue latency, then result on next cycle.
    push(4'h3, 8'h12, 8'h34);
    check("lat_cycle1", op_valid, 0);
    tick();
    check("lat_cycle2", op_valid, 1);
    expect_issue("t1_issue");
    respond(8'h46);

    // RES_VALID in HOLD is ignored.
    res_valid = 1'b1;
    res_data  = 8'h77;
    tick();
    res_valid = 1'b0;
    check("hold_ign_data", out_data, 8'h46);
    check("hold_ign_valid", out_valid, 1);
    take_result("t1_out");

    // RES_VALID in IDLE with an empty FIFO is ignored; OP_* keep last values.
    tick();
    res_valid = 1'b1;
    res_data  = 8'h99;
    tick();
    res_valid = 1'b0;
    tick();
    check("idle_ign_out_valid", out_valid, 0);
    check("idle_ign_op_valid", op_valid, 0);
    check("idle_ign_out_data", out_data, 8'h46);
    check("idle_op_code_held", op_code, 4'h3);

    // Result arrives in the 16th BUSY cycle: the result wins, no error.
    push(4'h7, 8'hAA, 8'h55);
    expect_issue("bnd_issue");
    repeat (15) tick();
    check("bnd_no_early_out", out_valid, 0);
    check("bnd_still_busy", op_valid, 1);
    respond(8'h5A);
    check("bnd_no_err", timeout_err, 0);
    take_result("bnd_out");

    // Five back-to-back pushes with OUT_READY low: FIFO fills behind the in-flight op.
    for (int i = 0; i < 5; i++) push(4'(i), 8'(8'h10 + i), 8'(8'h20 + i));
    check("fill_in_ready", in_ready, 0);
    expect_issue("fill_issue0");
    respond(8'hA0);
    repeat (3) tick();
    check("fill_hold_valid", out_valid, 1);
    check("fill_hold_data", out_data, 8'hA0);
    check("fill_hold_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        expect_issue("drain_issue");
        respond(8'(8'hA0 + i));
      end
      take_result("drain_out");
      check("drain_gap0", op_valid, 0);
      tick();
      check("drain_gap1", op_valid, (i < 4) ? 1 : 0);
    end

    // Timeout: no RES_VALID for 16 BUSY cycles.
    push(4'hF, 8'h01, 8'h02);
    expect_issue("to_issue");
    repeat (15) tick();
    check("to_not_yet_err", timeout_err, 0);
    check("to_not_yet_out", out_valid, 0);
    tick();
    check("to_err", timeout_err, 1);
    check("to_out_valid", out_valid, 1);
    check("to_out_data", out_data, 8'hFF);
    check("to_op_valid", op_valid, 0);
    exp_res_q.push_back(8'hFF);
    take_result("to_out");
    push(4'h9, 8'h0F, 8'hF0);
    expect_issue("post_to_issue");
    respond(8'h33);
    take_result("post_to_out");
    check("to_sticky", timeout_err, 1);

    // Reset mid-BUSY with three entries queued behind the in-flight op.
    for (int i = 0; i < 4; i++) push(4'(8 + i), 8'(8'h40 + i), 8'(8'h50 + i));
    expect_issue("mid_issue");
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_op_valid", op_valid, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_err", timeout_err, 0);
    exp_op_q.delete();
    exp_res_q.delete();
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", in_ready, 1);
    repeat (5) tick();
    check("mid_no_stale_op", op_valid, 0);
    check("mid_no_stale_out", out_valid, 0);
    push(4'hC, 8'hDE, 8'hAD);
    expect_issue("post_rst_issue");
    respond(8'hBE);
    take_result("post_rst_out");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
